fp_mul_sched: RTL and testbench

//   Shares one combinational FP32 multiplier (fp_mul) between two requesters.

---
 rtl/fp_mul_sched.sv | 154 +++++++++++++++
 tb/tb_fp_mul_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one combinational FP32 multiplier between two requesters.
// Optional sticky exception flags are enabled by defining FPMUL_STICKY_FLAGS_EN.
module fp_mul_sched #(
    parameter int unsigned TAG_W   = 4,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_x,
    input  logic [31:0]      req0_y,
    input  logic [2:0]       req0_rm,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_x,
    input  logic [31:0]      req1_y,
    input  logic [2:0]       req1_rm,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      mul_x,
    output logic [31:0]      mul_y,
    output logic [2:0]       mul_rmode,
    input  logic [31:0]      mul_z,
    input  logic             mul_ovrf,
    input  logic             mul_udrf,
    input  logic             mul_zer,
    input  logic             mul_inf,
    input  logic             mul_nan,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_src,
    output logic [31:0]      rsp_z,
    output logic [TAG_W-1:0] rsp_tag,
`ifdef FPMUL_STICKY_FLAGS_EN
    output logic [4:0]       rsp_flags,
    input  logic             flags_clr,
    output logic [4:0]       sticky_flags
`else
    output logic [4:0]       rsp_flags
`endif
);

    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam logic [4:0]  NAN_FLAGS = 5'b10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             op_src;
    logic             op_illegal;
    logic [TAG_W-1:0] op_tag;

    logic             grant_c;
    logic             grant_src_c;
    logic [31:0]      sel_x_c;
    logic [31:0]      sel_y_c;
    logic [2:0]       sel_rm_c;
    logic [TAG_W-1:0] sel_tag_c;

    // Grant only in IDLE; on contention favour the requester not served last.
    always_comb begin
        grant_c     = 1'b0;
        grant_src_c = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_c     = 1'b1;
                grant_src_c = ~last_grant;
            end else if (req0_valid) begin
                grant_c     = 1'b1;
                grant_src_c = 1'b0;
            end else if (req1_valid) begin
                grant_c     = 1'b1;
                grant_src_c = 1'b1;
            end
        end
        sel_x_c   = grant_src_c ? req1_x   : req0_x;
        sel_y_c   = grant_src_c ? req1_y   : req0_y;
        sel_rm_c  = grant_src_c ? req1_rm  : req0_rm;
        sel_tag_c = grant_src_c ? req1_tag : req0_tag;
    end

    assign req0_ready = grant_c & ~grant_src_c;
    assign req1_ready = grant_c &  grant_src_c;

    // Operand regs double as the multiplier inputs so they hold outside EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ~RR_INIT;
            op_src     <= 1'b0;
            op_illegal <= 1'b0;
            op_tag     <= '0;
            mul_x      <= '0;
            mul_y      <= '0;
            mul_rmode  <= '0;
            rsp_valid  <= 1'b0;
            rsp_src    <= 1'b0;
            rsp_z      <= '0;
            rsp_tag    <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        mul_x      <= sel_x_c;
                        mul_y      <= sel_y_c;
                        mul_rmode  <= sel_rm_c;
                        op_tag     <= sel_tag_c;
                        op_src     <= grant_src_c;
                        op_illegal <= (sel_rm_c > 3'd4);
                        last_grant <= grant_src_c;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_z     <= op_illegal ? QNAN : mul_z;
                    rsp_flags <= op_illegal ? NAN_FLAGS
                                            : {mul_nan, mul_inf, mul_zer, mul_ovrf, mul_udrf};
                    rsp_src   <= op_src;
                    rsp_tag   <= op_tag;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FPMUL_STICKY_FLAGS_EN
    // Clear and accumulate in one step so a coinciding handshake's flags survive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_flags <= '0;
        end else if (rsp_valid && rsp_ready) begin
            sticky_flags <= (flags_clr ? 5'b00000 : sticky_flags) | rsp_flags;
        end else if (flags_clr) begin
            sticky_flags <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed self-checking bench for fp_mul_sched with a small table-driven multiplier stand-in.
module tb_fp_mul_sched;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic [2:0]  req0_rm, req1_rm;
    logic [3:0]  req0_tag, req1_tag;
    logic [31:0] mul_x, mul_y, mul_z;
    logic [2:0]  mul_rmode;
    logic        mul_ovrf, mul_udrf, mul_zer, mul_inf, mul_nan;
    logic        rsp_valid, rsp_ready, rsp_src;
    logic [31:0] rsp_z;
    logic [3:0]  rsp_tag;
    logic [4:0]  rsp_flags;
`ifdef FPMUL_STICKY_FLAGS_EN
    logic        flags_clr;
    logic [4:0]  sticky_flags;
`endif

    int passed = 0;
    int total  = 0;

    fp_mul_sched #(.TAG_W(4), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req0_rm(req0_rm), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .req1_rm(req1_rm), .req1_tag(req1_tag),
        .mul_x(mul_x), .mul_y(mul_y), .mul_rmode(mul_rmode), .mul_z(mul_z),
        .mul_ovrf(mul_ovrf), .mul_udrf(mul_udrf), .mul_zer(mul_zer), .mul_inf(mul_inf),
        .mul_nan(mul_nan),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_z(rsp_z),
        .rsp_tag(rsp_tag),
`ifdef FPMUL_STICKY_FLAGS_EN
        .rsp_flags(rsp_flags), .flags_clr(flags_clr), .sticky_flags(sticky_flags)
`else
        .rsp_flags(rsp_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: zero operand, identity for 1.0, and 3.0*3.0.
    always_comb begin
        mul_z    = 32'hDEAD_BEEF;
        mul_ovrf = 1'b0;
        mul_udrf = 1'b0;
        mul_zer  = 1'b0;
        mul_inf  = 1'b0;
        mul_nan  = 1'b0;
        if (mul_x == 32'h0 || mul_y == 32'h0) begin
            mul_z   = 32'h0;
            mul_zer = 1'b1;
        end else if (mul_x == 32'h3F80_0000) begin
            mul_z = mul_y;
        end else if (mul_x == 32'h4040_0000 && mul_y == 32'h4040_0000) begin
            mul_z = 32'h4110_0000;
        end
    end

    task automatic drive_req(input bit s, input logic [31:0] x, input logic [31:0] y,
                             input logic [2:0] rm, input logic [3:0] tag);
        if (s) begin
            req1_valid = 1'b1; req1_x = x; req1_y = y; req1_rm = rm; req1_tag = tag;
        end else begin
            req0_valid = 1'b1; req0_x = x; req0_y = y; req0_rm = rm; req0_tag = tag;
        end
    endtask

    // Issue one op and return positioned at the first cycle with rsp_valid high.
    task automatic run_op(input bit s, input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] rm, input logic [3:0] tag);
        int cyc;
        @(negedge clk);
        drive_req(s, x, y, rm, tag);
        rsp_ready = 1'b1;
        #1;
        cyc = 0;
        while (!(s ? req1_ready : req0_ready) && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        if (cyc >= 20) begin
            total++;
            $display("FAIL run_op_ready_timeout src=%0d", s);
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        if (cyc >= 20) begin
            total++;
            $display("FAIL run_op_rsp_timeout src=%0d", s);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); else passed++;
        total++; if (mul_x !== 32'h0 || mul_y !== 32'h0 || mul_rmode !== 3'h0)
            $display("FAIL reset_mul got=%h %h %h exp=0", mul_x, mul_y, mul_rmode); else passed++;
        total++; if (rsp_z !== 32'h0 || rsp_tag !== 4'h0 || rsp_src !== 1'b0 || rsp_flags !== 5'h0)
            $display("FAIL reset_rsp got=%h %h %b %b exp=0", rsp_z, rsp_tag, rsp_src, rsp_flags); else passed++;
`ifdef FPMUL_STICKY_FLAGS_EN
        total++; if (sticky_flags !== 5'h0) $display("FAIL reset_sticky got=%b exp=00000", sticky_flags); else passed++;
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        @(negedge clk);
        drive_req(1'b0, 32'h4040_0000, 32'h4040_0000, 3'b001, 4'd3);
        rsp_ready = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL basic_grant got=%b%b exp=10", req0_ready, req1_ready); else passed++;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL basic_exec_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        total++; if (mul_x !== 32'h4040_0000 || mul_y !== 32'h4040_0000 || mul_rmode !== 3'b001)
            $display("FAIL basic_mul_ops got=%h %h %b exp=40400000 40400000 001", mul_x, mul_y, mul_rmode); else passed++;
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 1'b1) $display("FAIL basic_latency got=%b exp=1", rsp_valid); else passed++;
        total++; if (rsp_z !== 32'h4110_0000) $display("FAIL basic_z got=%h exp=41100000", rsp_z); else passed++;
        total++; if (rsp_src !== 1'b0 || rsp_tag !== 4'd3 || rsp_flags !== 5'b00000)
            $display("FAIL basic_meta got=%b %0d %b exp=0 3 00000", rsp_src, rsp_tag, rsp_flags); else passed++;
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL basic_rsp_drop got=%b exp=0", rsp_valid); else passed++;
        total++; if (mul_x !== 32'h4040_0000) $display("FAIL basic_mul_hold got=%h exp=40400000", mul_x); else passed++;
    endtask

    task automatic test_round_robin;
        int n0, n1, ng, nr, e0, e1, cyc;
        bit g0, g1;
        logic [3:0] exp_tag;
        test_reset();
        n0 = 0; n1 = 0; ng = 0; nr = 0; e0 = 0; e1 = 0; cyc = 0;
        rsp_ready = 1'b1;
        while (nr < 8 && cyc < 80) begin
            @(negedge clk);
            req0_valid = (n0 < 4);
            req0_x = 32'h3F80_0000; req0_y = 32'h4000_0000 + 32'(n0); req0_rm = 3'b000; req0_tag = 4'(n0);
            req1_valid = (n1 < 4);
            req1_x = 32'h3F80_0000; req1_y = 32'h4100_0000 + 32'(n1); req1_rm = 3'b000; req1_tag = 4'(8 + n1);
            #1;
            g0 = req0_ready; g1 = req1_ready;
            if (g0 || g1) begin
                total++;
                if (g1 !== 1'(ng % 2) || (g0 && g1))
                    $display("FAIL rr_grant idx=%0d got=%b%b exp_src=%0d", ng, g0, g1, ng % 2);
                else passed++;
                ng++;
            end
            if (rsp_valid) begin
                exp_tag = rsp_src ? 4'(8 + e1) : 4'(e0);
                total++;
                if (rsp_tag !== exp_tag || rsp_src !== 1'(nr % 2))
                    $display("FAIL rr_rsp idx=%0d got src=%b tag=%0d exp src=%0d tag=%0d",
                             nr, rsp_src, rsp_tag, nr % 2, exp_tag);
                else passed++;
                total++;
                if (rsp_z !== (rsp_src ? 32'h4100_0000 + 32'(e1) : 32'h4000_0000 + 32'(e0)))
                    $display("FAIL rr_rsp_z idx=%0d got=%h", nr, rsp_z);
                else passed++;
                if (rsp_src) e1++; else e0++;
                nr++;
            end
            @(posedge clk);
            if (g0) n0++;
            if (g1) n1++;
            cyc++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++; if (nr != 8) $display("FAIL rr_timeout got=%0d exp=8 responses", nr); else passed++;
    endtask

    task automatic test_stall;
        @(negedge clk);
        drive_req(1'b0, 32'h3F80_0000, 32'h4040_0000, 3'b000, 4'd5);
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        drive_req(1'b1, 32'h3F80_0000, 32'h4080_0000, 3'b000, 4'd6);
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_z !== 32'h4040_0000 || rsp_tag !== 4'd5 || rsp_src !== 1'b0)
                $display("FAIL stall_hold cyc=%0d got=%b %h %0d %b exp=1 40400000 5 0",
                         k, rsp_valid, rsp_z, rsp_tag, rsp_src);
            else passed++;
            total++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
                $display("FAIL stall_ready cyc=%0d got=%b%b exp=00", k, req0_ready, req1_ready);
            else passed++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b0) $display("FAIL stall_no_same_cycle_grant got=%b exp=0", req1_ready); else passed++;
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0 || req1_ready !== 1'b1)
            $display("FAIL stall_idle_after got=%b %b exp=0 1", rsp_valid, req1_ready); else passed++;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 1'b1 || rsp_src !== 1'b1 || rsp_z !== 32'h4080_0000 || rsp_tag !== 4'd6)
            $display("FAIL stall_next got=%b %b %h %0d exp=1 1 40800000 6", rsp_valid, rsp_src, rsp_z, rsp_tag);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_illegal_rm;
        run_op(1'b1, 32'h3F80_0000, 32'h4000_0000, 3'b101, 4'd2);
        total++; if (rsp_z !== 32'h7FC0_0000) $display("FAIL illegal_z got=%h exp=7fc00000", rsp_z); else passed++;
        total++; if (rsp_flags !== 5'b10000 || rsp_src !== 1'b1)
            $display("FAIL illegal_flags got=%b src=%b exp=10000 src=1", rsp_flags, rsp_src); else passed++;
        @(negedge clk);
    endtask

    task automatic test_zero;
        run_op(1'b0, 32'h0, 32'h0, 3'b000, 4'd7);
        total++; if (rsp_z !== 32'h0) $display("FAIL zero_z got=%h exp=00000000", rsp_z); else passed++;
        total++; if (rsp_flags !== 5'b00100) $display("FAIL zero_flags got=%b exp=00100", rsp_flags); else passed++;
        @(negedge clk);
    endtask

`ifdef FPMUL_STICKY_FLAGS_EN
    task automatic test_sticky;
        #1;
        total++; if (sticky_flags !== 5'b10100) $display("FAIL sticky_accum got=%b exp=10100", sticky_flags); else passed++;
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        #1;
        total++; if (sticky_flags !== 5'b00000) $display("FAIL sticky_clr got=%b exp=00000", sticky_flags); else passed++;
    endtask
`endif

    task automatic test_reset_exec;
        bit seen;
        @(negedge clk);
        drive_req(1'b0, 32'h4040_0000, 32'h4040_0000, 3'b001, 4'd9);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL rexec_rsp_valid got=%b exp=0", rsp_valid); else passed++;
        total++; if (mul_x !== 32'h0 || mul_y !== 32'h0 || mul_rmode !== 3'h0 || rsp_z !== 32'h0 || rsp_tag !== 4'h0)
            $display("FAIL rexec_outputs got=%h %h %h %h %h exp=0", mul_x, mul_y, mul_rmode, rsp_z, rsp_tag); else passed++;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL rexec_dropped got=1 exp=0 (response after reset)"); else passed++;
        test_basic();
    endtask

    initial begin
        rst_n = 1'b1;
        req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_rm = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_rm = '0; req1_tag = '0;
        rsp_ready = 1'b0;
`ifdef FPMUL_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_illegal_rm();
        test_zero();
`ifdef FPMUL_STICKY_FLAGS_EN
        test_sticky();
`endif
        test_reset_exec();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
